// File: rtl/mcpu_pkg.sv
`timescale 1ns/1ps
// MCPU instruction field layout, destination codes and emitter state encoding.
// Shared by the immediate emitter and its length helper.
package mcpu_pkg;

  localparam int IMM_BIT  = 7;
  localparam int COND_BIT = 6;
  localparam int DST_LSB  = 3;
  localparam int DST_W    = 3;
  localparam int SRC_LSB  = 0;
  localparam int SRC_W    = 3;

  localparam logic [SRC_W-1:0] SRC_IMM = 3'b011;

  localparam logic [DST_W-1:0] DST_PC    = 3'd0;
  localparam logic [DST_W-1:0] DST_ADDR  = 3'd1;
  localparam logic [DST_W-1:0] DST_RAM   = 3'd2;
  localparam logic [DST_W-1:0] DST_ALU_A = 3'd3;
  localparam logic [DST_W-1:0] DST_ALU_B = 3'd4;
  localparam logic [DST_W-1:0] DST_I     = 3'd5;
  localparam logic [DST_W-1:0] DST_J     = 3'd6;
  localparam logic [DST_W-1:0] DST_K     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IMM  = 2'd1,
    ST_MOV  = 2'd2
  } state_e;

  // 7-bit payload of IMM chunk idx; chunk 4 only carries the top nibble.
  function automatic logic [6:0] imm_chunk(input logic [31:0] value, input logic [2:0] idx);
    logic [6:0] c;
    case (idx)
      3'd0:    c = value[6:0];
      3'd1:    c = value[13:7];
      3'd2:    c = value[20:14];
      3'd3:    c = value[27:21];
      3'd4:    c = {3'b000, value[31:28]};
      default: c = 7'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mcpu_imm_len.sv
`timescale 1ns/1ps
// Minimal IMM chunk count (1..5) for a 32-bit value; purely combinational.
// Finds the most significant non-zero 7-bit group; zero still needs one chunk.
module mcpu_imm_len (
  input  logic [31:0] value,
  output logic [2:0]  n_chunks
);

  always_comb begin
    if (|value[31:28])      n_chunks = 3'd5;
    else if (|value[27:21]) n_chunks = 3'd4;
    else if (|value[20:14]) n_chunks = 3'd3;
    else if (|value[13:7])  n_chunks = 3'd2;
    else                    n_chunks = 3'd1;
  end

endmodule

// File: rtl/mcpu_imm_emitter.sv
`timescale 1ns/1ps
// Emits IMM chunks (MSB first) plus one MOV per request, each tagged with its program address.
// First byte one cycle after accept; out_byte/out_addr hold while out_ready is low.
module mcpu_imm_emitter
  import mcpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_value,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_value,
  input  logic [2:0]        req_dst,
  input  logic              req_cond,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done
);

  state_e            state_q, state_d;
  logic [31:0]       value_q, value_d;
  logic [2:0]        dst_q, dst_d;
  logic              cond_q, cond_d;
  logic [2:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        n_chunks;

  mcpu_imm_len u_len (
    .value    (req_value),
    .n_chunks (n_chunks)
  );

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    dst_d   = dst_q;
    cond_d  = cond_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        // Load takes effect before the accept, so the first byte lands at addr_value.
        if (addr_load) addr_d = addr_value;
        if (req_valid) begin
          value_d = req_value;
          dst_d   = req_dst;
          cond_d  = req_cond;
          idx_d   = n_chunks - 3'd1;
          state_d = ST_IMM;
        end
      end
      ST_IMM: begin
        if (out_ready) begin
          addr_d = addr_q + ADDR_W'(1);
          if (idx_q == 3'd0) state_d = ST_MOV;
          else               idx_d   = idx_q - 3'd1;
        end
      end
      ST_MOV: begin
        if (out_ready) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      dst_q   <= '0;
      cond_q  <= 1'b0;
      idx_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      dst_q   <= dst_d;
      cond_q  <= cond_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    out_byte = 8'h00;
    case (state_q)
      ST_IMM:  out_byte = {1'b1, imm_chunk(value_q, idx_q)};
      ST_MOV:  out_byte = {1'b0, cond_q, dst_q, SRC_IMM};
      default: out_byte = 8'h00;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_IMM) || (state_q == ST_MOV);
  assign out_addr  = addr_q;
  assign done      = (state_q == ST_MOV) && out_ready;

endmodule

// File: tb/tb_mcpu_imm_emitter.sv
`timescale 1ns/1ps
// Directed bench for mcpu_imm_emitter with a byte/address scoreboard.
module tb_mcpu_imm_emitter;
  import mcpu_pkg::*;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          addr_load = 1'b0;
  logic [AW-1:0] addr_value = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_value = '0;
  logic [2:0]    req_dst = '0;
  logic          req_cond = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_byte;
  logic [AW-1:0] out_addr;
  logic          done;

  typedef struct packed {
    logic [7:0]    b;
    logic [AW-1:0] a;
    logic          mov;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [AW-1:0] exp_addr = '0;
  int            checks = 0;
  int            passed = 0;

  mcpu_imm_emitter #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr_load  (addr_load),
    .addr_value (addr_value),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_value  (req_value),
    .req_dst    (req_dst),
    .req_cond   (req_cond),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .out_addr   (out_addr),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference encoding: grow the chunk count until the remaining high bits are zero.
  task automatic push_req(input logic [31:0] v, input logic [2:0] d, input logic c);
    int n;
    logic [31:0] chunk;
    n = 1;
    while (n < 5 && (v >> (7 * n)) != 32'd0) n++;
    for (int k = n - 1; k >= 0; k--) begin
      chunk = (v >> (7 * k)) & 32'h7F;
      sb.push_back('{b: 8'h80 | chunk[7:0], a: exp_addr, mov: 1'b0});
      exp_addr = exp_addr + 1;
    end
    sb.push_back('{b: {1'b0, c, d, 3'b011}, a: exp_addr, mov: 1'b1});
    exp_addr = exp_addr + 1;
  endtask

  task automatic send(input logic [31:0] v, input logic [2:0] d, input logic c);
    check("req_ready_idle", req_ready, 1);
    push_req(v, d, c);
    req_value = v;
    req_dst   = d;
    req_cond  = c;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("req_ready_busy", req_ready, 0);
    check("first_byte_valid", out_valid, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
    check("ready_after_mov", req_ready, 1);
    check("idle_out_valid", out_valid, 0);
  endtask

  always @(negedge clk) begin
    if (reset && out_valid === 1'b1 && out_ready) begin
      checks++;
      assert (sb.size() > 0) passed++;
      else $error("FAIL extra_byte observed=0x%0h expected=none", out_byte);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("byte", out_byte, mon_e.b);
        check("addr", out_addr, mon_e.a);
        check("done", done, mon_e.mov);
        check("req_ready_low", req_ready, 0);
      end
    end
  end

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_out_addr", out_addr, 0);
    check("rst_done", done, 0);
    check("rst_out_byte", out_byte, 0);
    reset = 1'b1;

    // Address load, then a single-chunk request.
    addr_load  = 1'b1;
    addr_value = 32'h10;
    @(posedge clk);
    #1;
    addr_load = 1'b0;
    exp_addr  = 32'h10;
    check("addr_loaded", out_addr, 32'h10);
    send(32'd5, DST_I, 1'b0);
    drain();

    // Two chunks.
    send(32'd128, DST_ALU_A, 1'b0);
    drain();

    // Full width conditional jump; a mid-sequence addr_load must be ignored.
    send(32'hFFFF_FFFF, DST_PC, 1'b1);
    @(posedge clk);
    #1;
    addr_load  = 1'b1;
    addr_value = 32'h55;
    @(posedge clk);
    #1;
    addr_load = 1'b0;
    drain();

    // Backpressure on the second IMM byte.
    send(32'h0001_2345, DST_RAM, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_byte", out_byte, sb[0].b);
      check("stall_addr", out_addr, sb[0].a);
      check("stall_done", done, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Reset in the middle of an IMM run.
    send(32'hFFFF_FFFF, DST_J, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    reset     = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_out_addr", out_addr, 0);
    sb.delete();
    exp_addr  = '0;
    reset     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", out_valid, 0);
    send(32'd0, DST_RAM, 1'b0);
    drain();

    // Address wrap, with the load in the same cycle as the accept.
    addr_load  = 1'b1;
    addr_value = 32'hFFFF_FFFF;
    exp_addr   = 32'hFFFF_FFFF;
    send(32'd1, DST_K, 1'b0);
    addr_load = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mcpu_imm_emitter.md
Name: mcpu_imm_emitter

Overview:
- Instruction encoder for the MCPU 8-bit instruction format; it is the counterpart of the core's instruction decoder.
- Takes a request "load 32-bit value V into destination D, optionally conditionally" and emits the minimal MCPU byte sequence that does it: IMM chunks, MSB first, then one MOV D<-IMM.
- Each byte carries its program-memory address, for a ROM loader or on-chip program generator.
- Sits between a host/loader FSM and the program ROM write port.

Parameters:
- ADDR_W, 32, width of the output address counter; wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
- addr_load  in  1  load the address counter from addr_value; honoured only in IDLE.
- addr_value  in  ADDR_W  new address counter value.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid&&req_ready.
- req_value  in  32  value to load.
- req_dst  in  3  destination code: PC=0, ADDR=1, RAM=2, ALU_A=3, ALU_B=4, I=5, J=6, K=7.
- req_cond  in  1  1 emits a conditional MOV (bit 6 set).
- out_valid  out  1  output byte valid.
- out_ready  in  1  consumer accepts the byte when out_valid&&out_ready.
- out_byte  out  8  instruction byte.
- out_addr  out  ADDR_W  program address of out_byte.
- done  out  1  one-cycle pulse on the MOV byte handshake.

Behaviour:
- Reset values: state=IDLE, out_valid=0, out_byte=0, out_addr=0, done=0, req_ready=1. Reset mid-sequence abandons it; no further bytes are emitted.
- States: IDLE, IMM, MOV.
- req_ready=1 only in IDLE.
- IDLE:
  - On accept, latch value/dst/cond.
  - Compute N = minimal chunk count in 1..5 with value < 2^(7N). value=0 gives N=1.
  - Set chunk index idx=N-1, go to IMM.
- IMM:
  - out_valid=1, out_byte = 0x80 | chunk[idx]. chunk[k] = value[7k+6:7k]; chunk[4] = {3'b0, value[31:28]}.
  - On handshake: if idx==0 go to MOV, else idx-1.
- MOV:
  - out_valid=1, out_byte = {1'b0, cond, dst, 3'b011}.
  - On handshake: done=1 for one cycle, go to IDLE.
- Latency:
  - Request accepted in cycle T gives the first byte valid in cycle T+1.
  - Bytes advance one per cycle under continuous out_ready.
  - After the MOV handshake, req_ready=1 the next cycle (one bubble between requests).
- Sequence length is N+1 bytes, 2..6.
- Backpressure: while out_valid && !out_ready, out_byte and out_addr are held stable. No byte is skipped or duplicated.
- out_addr:
  - Increments by 1 on every output handshake; wraps 2^ADDR_W-1 -> 0.
  - addr_load in IDLE sets out_addr=addr_value next cycle.
  - addr_load and request accept in the same cycle: the load applies first, so the first byte goes to addr_value.
  - addr_load outside IDLE is ignored.
- The sequence always starts after a MOV or after reset, so the core's IMM accumulator starts fresh. Consecutive IMM bytes shift-accumulate exactly to value.
- All dst codes are legal. PC yields a (conditional) jump; RAM yields a store to the current ADDR.
- out_valid=0 in IDLE.

Decomposition:
- Package mcpu_pkg holds:
  - IMM flag bit 7 and COND bit 6.
  - SRC/DST field positions and widths.
  - SRC_IMM=3'b011.
  - All 3-bit DST codes.
  - The state enum typedef.
- Sub-module mcpu_imm_len: combinational 32-bit value -> 3-bit N (1..5), a leading-zero-group detector. Instantiated once, usable by the assembler tooling testbench.

Test Plan:
1. Address load: addr_load=1, addr_value=0x10; then value=5, dst=5 (I), cond=0 -> 0x85@0x10, 0x2B@0x11; done pulses on the second handshake.
2. Two-chunk value: value=128, dst=3 (ALU_A) -> 0x81, 0x80, 0x1B at consecutive addresses; N=2 confirmed.
3. Full-width conditional: value=0xFFFFFFFF, dst=0 (PC), cond=1 -> 0x8F, 0xFF, 0xFF, 0xFF, 0xFF, 0x43; six bytes, req_ready low throughout.
4. Backpressure: out_ready=0 for 3 cycles during the second IMM byte -> out_byte/out_addr unchanged; the sequence resumes without skip or duplicate.
5. Reset mid-sequence: drive reset=0 during the IMM state -> next cycle out_valid=0, req_ready=1, out_addr=0; a new request value=0, dst=2 emits 0x80@0, 0x13@1.
6. Wrap: ADDR_W=4, addr_value=0xF, value=1, dst=7 (K) -> 0x81@0xF, 0x3B@0x0.
